// File: rtl/gemm_tile_ctrl_if.sv
// Start/size request and SRAM/MAC control bundle of the GEMM tile sequencer.
// Handshake: start_i is a single-cycle request, accepted only while busy_o=0;
// done_o (with err_o for rejected sizes) closes every accepted request.
interface gemm_tile_ctrl_if #(
    parameter int AddrWidth        = 12,
    parameter int SizeAddrWidth    = 8,
    parameter int NumParallelLanes = 4
);
    localparam int LaneW = $clog2(NumParallelLanes);

    logic                     start_i;
    logic [SizeAddrWidth-1:0] M_size_i;
    logic [SizeAddrWidth-1:0] K_size_i;
    logic [SizeAddrWidth-1:0] N_size_i;
    logic [AddrWidth-1:0]     sram_a_addr_o;
    logic [AddrWidth-1:0]     sram_b_addr_o;
    logic [AddrWidth-1:0]     sram_c_addr_o;
    logic                     sram_c_we_o;
    logic [LaneW-1:0]         a_lane_sel_o;
    logic                     mac_en_o;
    logic                     acc_clr_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     err_o;
    logic [2:0]               state_dbg;

    modport master (
        output start_i, M_size_i, K_size_i, N_size_i,
        input  sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
               a_lane_sel_o, mac_en_o, acc_clr_o, busy_o, done_o, err_o, state_dbg
    );

    modport slave (
        input  start_i, M_size_i, K_size_i, N_size_i,
        output sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
               a_lane_sel_o, mac_en_o, acc_clr_o, busy_o, done_o, err_o, state_dbg
    );
endinterface

// File: rtl/gemm_tile_ctrl.sv
// GEMM tile sequencer: walks every C tile (m outer, nb middle, k inner),
// issuing A/B read addresses, delayed MAC strobes and one C write per tile.
// Addresses come from incremental base registers only (no multipliers).
module gemm_tile_ctrl #(
    parameter int AddrWidth        = 12,
    parameter int SizeAddrWidth    = 8,
    parameter int NumKernels       = 4,
    parameter int NumParallelLanes = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    gemm_tile_ctrl_if.slave bus
);
    localparam int TileN     = NumKernels * NumParallelLanes;
    localparam int LaneW     = $clog2(NumParallelLanes);
    localparam int TileShift = $clog2(TileN);
    localparam logic [SizeAddrWidth-1:0] SizeOne = SizeAddrWidth'(1);
    localparam logic [AddrWidth-1:0]     AddrOne = AddrWidth'(1);

    typedef enum logic [2:0] {IDLE, RUN, WAIT, WRITE, DONE} state_t;

    state_t state, state_nx;

    logic [SizeAddrWidth-1:0] m_size_q, k_size_q, n_tiles_q, k_words_q;
    logic [SizeAddrWidth-1:0] m_q, nb_q, k_q;
    logic [AddrWidth-1:0]     a_row_base_q, a_addr_q, b_addr_q, c_addr_q;
    logic                     err_q, mac_en_q, acc_clr_q;
    logic [LaneW-1:0]         lane_q;

    logic                     size_bad, k_last, nb_wrap, last_tile;
    logic [SizeAddrWidth-1:0] nb_nx;
    logic [AddrWidth-1:0]     row_base_nx;

    // Size validation and loop-boundary decodes shared by FSM and datapath.
    always_comb begin
        size_bad = (bus.M_size_i == '0) || (bus.K_size_i == '0) || (bus.N_size_i == '0) ||
                   (bus.K_size_i[LaneW-1:0] != '0) || (bus.N_size_i[TileShift-1:0] != '0);
        k_last      = (k_q == k_size_q - SizeOne);
        nb_wrap     = (nb_q == n_tiles_q - SizeOne);
        last_tile   = nb_wrap && (m_q == m_size_q - SizeOne);
        nb_nx       = nb_wrap ? '0 : nb_q + SizeOne;
        row_base_nx = nb_wrap ? a_row_base_q + AddrWidth'(k_words_q) : a_row_base_q;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nx        = state;
        bus.busy_o      = (state != IDLE);
        bus.done_o      = (state == DONE);
        bus.err_o       = (state == DONE) && err_q;
        bus.sram_c_we_o = (state == WRITE);
        unique case (state)
            IDLE:    if (bus.start_i) state_nx = size_bad ? DONE : RUN;
            RUN:     if (k_last) state_nx = WAIT;
            WAIT:    state_nx = WRITE;
            WRITE:   state_nx = last_tile ? DONE : RUN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Size latch, loop counters, address bases and the one-cycle MAC strobe delay.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_size_q     <= '0;
            k_size_q     <= '0;
            n_tiles_q    <= '0;
            k_words_q    <= '0;
            m_q          <= '0;
            nb_q         <= '0;
            k_q          <= '0;
            a_row_base_q <= '0;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            c_addr_q     <= '0;
            err_q        <= 1'b0;
            mac_en_q     <= 1'b0;
            acc_clr_q    <= 1'b0;
            lane_q       <= '0;
        end else begin
            // Read data returns one cycle after issue, so the strobes trail RUN.
            mac_en_q  <= (state == RUN);
            acc_clr_q <= (state == RUN) && (k_q == '0);
            lane_q    <= (state == RUN) ? k_q[LaneW-1:0] : '0;
            unique case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        m_size_q  <= bus.M_size_i;
                        k_size_q  <= bus.K_size_i;
                        n_tiles_q <= bus.N_size_i >> TileShift;
                        k_words_q <= bus.K_size_i >> LaneW;
                        err_q     <= size_bad;
                        if (!size_bad) begin
                            m_q          <= '0;
                            nb_q         <= '0;
                            k_q          <= '0;
                            a_row_base_q <= '0;
                            a_addr_q     <= '0;
                            b_addr_q     <= '0;
                            c_addr_q     <= '0;
                        end
                    end
                end
                RUN: begin
                    // Addresses hold the last issued value once k reaches K-1.
                    if (!k_last) begin
                        k_q      <= k_q + SizeOne;
                        b_addr_q <= b_addr_q + AddrWidth'(n_tiles_q);
                        if (k_q[LaneW-1:0] == '1) a_addr_q <= a_addr_q + AddrOne;
                    end
                end
                WRITE: begin
                    c_addr_q     <= c_addr_q + AddrOne;
                    nb_q         <= nb_nx;
                    a_row_base_q <= row_base_nx;
                    if (nb_wrap) m_q <= m_q + SizeOne;
                    if (!last_tile) begin
                        k_q      <= '0;
                        a_addr_q <= row_base_nx;
                        b_addr_q <= AddrWidth'(nb_nx);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sram_a_addr_o = a_addr_q;
    assign bus.sram_b_addr_o = b_addr_q;
    assign bus.sram_c_addr_o = c_addr_q;
    assign bus.mac_en_o      = mac_en_q;
    assign bus.acc_clr_o     = acc_clr_q;
    assign bus.a_lane_sel_o  = lane_q;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// Bench for gemm_tile_ctrl: a per-cycle expectation queue built from the loop
// rules, memory/MAC models driven by the DUT strobes, and a golden GEMM.
module tb_gemm_tile_ctrl;
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        we;
        logic [11:0] c_addr;
        logic        mac;
        logic        clr;
        logic [1:0]  lane;
        logic [11:0] a;
        logic [11:0] b;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [11:0] held_a = '0;
    logic [11:0] held_b = '0;

    logic [31:0]  amem [0:255];
    logic [127:0] bmem [0:255];
    logic [31:0]  cmem [0:255][0:15];
    logic [31:0]  a_rd;
    logic [127:0] b_rd;
    int           acc [16];
    int           wr_cnt = 0;

    gemm_tile_ctrl_if bus ();

    gemm_tile_ctrl dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    // Clock / reset block
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int prod(input logic [31:0] aw, input logic [1:0] ln,
                                input logic [127:0] bw, input int j);
        logic signed [7:0] av, bv;
        av = aw[ln*8 +: 8];
        bv = bw[j*8 +: 8];
        return int'(av) * int'(bv);
    endfunction

    // SRAM models (1-cycle read latency) and the kernel-array accumulators.
    always @(posedge clk_i) begin
        a_rd <= amem[bus.sram_a_addr_o[7:0]];
        b_rd <= bmem[bus.sram_b_addr_o[7:0]];
        if (bus.mac_en_o)
            for (int j = 0; j < 16; j++)
                acc[j] <= (bus.acc_clr_o ? 0 : acc[j]) + prod(a_rd, bus.a_lane_sel_o, b_rd, j);
        if (bus.sram_c_we_o) begin
            for (int j = 0; j < 16; j++) cmem[bus.sram_c_addr_o[7:0]][j] <= acc[j];
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Expected per-cycle outputs of one start request, from the loop rules.
    task automatic push_job(input int mm, input int kk, input int nn, output int len);
        exp_t e;
        int nt, kw, t, p, mi, nbi;
        e = '0;
        if (mm == 0 || kk == 0 || nn == 0 || kk % 4 != 0 || nn % 16 != 0) begin
            e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1;
            e.a = held_a; e.b = held_b;
            exp_q.push_back(e);
            len = 1;
        end else begin
            nt  = nn / 16;
            kw  = kk / 4;
            len = 1 + mm * nt * (kk + 2);
            for (int i = 1; i <= len; i++) begin
                e = '0;
                e.busy = 1'b1;
                if (i == len) e.done = 1'b1;
                else begin
                    t   = (i - 1) / (kk + 2);
                    p   = (i - 1) % (kk + 2);
                    mi  = t / nt;
                    nbi = t % nt;
                    if (p < kk) begin
                        held_a = 12'(mi * kw + p / 4);
                        held_b = 12'(p * nt + nbi);
                    end
                    if (p >= 1 && p <= kk) begin
                        e.mac  = 1'b1;
                        e.clr  = (p == 1);
                        e.lane = 2'((p - 1) % 4);
                    end
                    if (p == kk + 1) begin
                        e.we = 1'b1;
                        e.c_addr = 12'(t);
                    end
                end
                e.a = held_a; e.b = held_b;
                exp_q.push_back(e);
            end
        end
        e = '0;
        e.a = held_a; e.b = held_b;
        exp_q.push_back(e);
    endtask

    // Scoreboard compare: one expected entry per cycle, sampled after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("busy", 32'(bus.busy_o), 32'(e.busy));
                chk("done", 32'(bus.done_o), 32'(e.done));
                chk("err", 32'(bus.err_o), 32'(e.err));
                chk("c_we", 32'(bus.sram_c_we_o), 32'(e.we));
                chk("mac_en", 32'(bus.mac_en_o), 32'(e.mac));
                chk("acc_clr", 32'(bus.acc_clr_o), 32'(e.clr));
                chk("a_addr", 32'(bus.sram_a_addr_o), 32'(e.a));
                chk("b_addr", 32'(bus.sram_b_addr_o), 32'(e.b));
                if (e.we)  chk("c_addr", 32'(bus.sram_c_addr_o), 32'(e.c_addr));
                if (e.mac) chk("lane", 32'(bus.a_lane_sel_o), 32'(e.lane));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, 32'(bus.sram_a_addr_o), 0);
        chk({tag, "_b"}, 32'(bus.sram_b_addr_o), 0);
        chk({tag, "_c"}, 32'(bus.sram_c_addr_o), 0);
        chk({tag, "_we"}, 32'(bus.sram_c_we_o), 0);
        chk({tag, "_lane"}, 32'(bus.a_lane_sel_o), 0);
        chk({tag, "_mac"}, 32'(bus.mac_en_o), 0);
        chk({tag, "_clr"}, 32'(bus.acc_clr_o), 0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 0);
        chk({tag, "_done"}, 32'(bus.done_o), 0);
        chk({tag, "_err"}, 32'(bus.err_o), 0);
    endtask

    task automatic drive_sizes(input int mm, input int kk, input int nn);
        bus.M_size_i = 8'(mm);
        bus.K_size_i = 8'(kk);
        bus.N_size_i = 8'(nn);
    endtask

    // Driver: called at a negedge; returns at the negedge of the cycle after done.
    task automatic run_job(input int mm, input int kk, input int nn, input bit poke);
        int len, poke_at;
        bus.start_i = 1'b1;
        drive_sizes(mm, kk, nn);
        push_job(mm, kk, nn, len);
        poke_at = (poke && len > 2) ? int'($urandom_range(1, len - 1)) : -1;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk_i);
            bus.start_i = (c == poke_at);
            drive_sizes($urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(0, 64));
        end
        @(negedge clk_i);
        bus.start_i = 1'b0;
    endtask

    task automatic rand_job(input bit poke);
        int mm, kk, nn;
        mm = $urandom_range(1, 3);
        kk = 4 * $urandom_range(1, 5);
        nn = 16 * $urandom_range(1, 3);
        case ($urandom_range(0, 7))
            0: kk = kk + $urandom_range(1, 3);
            1: nn = nn + $urandom_range(1, 15);
            2: mm = 0;
            default: ;
        endcase
        run_job(mm, kk, nn, poke);
    endtask

    initial begin
        int len, wr0, sum, mi, ni;
        bus.start_i = 1'b0;
        drive_sizes(0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            amem[i] = $urandom;
            bmem[i] = {$urandom, $urandom, $urandom, $urandom};
        end

        // Hand-computed points pinning the expectation model.
        push_job(1, 4, 16, len);
        chk("pin_len_min", 32'(len), 7);
        chk("pin_b_cyc4", 32'(exp_q[3].b), 3);
        chk("pin_clr_cyc2", 32'(exp_q[1].clr), 1);
        chk("pin_we_cyc6", 32'(exp_q[5].we), 1);
        chk("pin_done_cyc7", 32'(exp_q[6].done), 1);
        exp_q.delete();
        push_job(4, 16, 64, len);
        chk("pin_len_full", 32'(len), 289);
        chk("pin_b_cyc2", 32'(exp_q[1].b), 4);
        chk("pin_a_cyc5", 32'(exp_q[4].a), 1);
        chk("pin_a_cyc16", 32'(exp_q[15].a), 3);
        chk("pin_last_c", 32'(exp_q[287].c_addr), 15);
        exp_q.delete();
        held_a = '0;
        held_b = '0;

        // Reset state.
        repeat (3) @(negedge clk_i);
        chk_all_zero("rst");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Minimal run, then a back-to-back run.
        run_job(1, 4, 16, 1'b0);
        run_job(2, 8, 32, 1'b0);
        repeat (2) @(negedge clk_i);

        // Full run with golden GEMM.
        wr0 = wr_cnt;
        run_job(4, 16, 64, 1'b0);
        chk("full_writes", 32'(wr_cnt - wr0), 16);
        for (int m = 0; m < 4; m++)
            for (int n = 0; n < 64; n++) begin
                sum = 0;
                for (int k = 0; k < 16; k++)
                    sum += prod(amem[m * 4 + k / 4], 2'(k % 4), bmem[k * 4 + n / 16], n % 16);
                mi = m * 4 + n / 16;
                ni = n % 16;
                chk("c_elem", cmem[mi][ni], 32'(sum));
            end

        // Rejected sizes.
        wr0 = wr_cnt;
        run_job(1, 6, 16, 1'b0);
        run_job(1, 4, 0, 1'b0);
        run_job(0, 4, 16, 1'b0);
        chk("rej_writes", 32'(wr_cnt - wr0), 0);

        // Start while busy, then randomized jobs.
        run_job(2, 12, 32, 1'b1);
        for (int r = 0; r < 8; r++) begin
            rand_job(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        // Reset mid-run.
        bus.start_i = 1'b1;
        drive_sizes(3, 8, 32);
        push_job(3, 8, 32, len);
        @(negedge clk_i);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b0;
        exp_q.delete();
        held_a = '0;
        held_b = '0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk_i);
        chk("rst_done_low", 32'(bus.done_o), 0);
        chk("rst_busy_low", 32'(bus.busy_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_job(1, 4, 16, 1'b0);

        repeat (3) @(negedge clk_i);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gemm_tile_ctrl.md
# gemm_tile_ctrl

Sequencing controller for the GEMM accelerator datapath. On `start_i` it latches the matrix sizes M, K and N, then walks every output tile of C. It generates the SRAM A, B and C addresses plus the MAC control strobes (lane select, accumulate, clear, write), and signals completion with a `done_o` pulse. It sits between the top-level start/size interface and the kernel array. It replaces ad-hoc address counters inside the top.

## Interface
- `AddrWidth`, 12, width of every SRAM address.
- `SizeAddrWidth`, 8, width of the M/K/N size inputs.
- `NumKernels`, 4, kernels per tile.
- `NumParallelLanes`, 4, int8 elements per A word; also lanes per kernel.
- Derived `TileN` = NumKernels*NumParallelLanes (16): C columns per tile, B elements per word.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start request; sampled only in IDLE.
- `M_size_i`, `K_size_i`, `N_size_i` in SizeAddrWidth: matrix sizes; sampled with `start_i`.
- `sram_a_addr_o` out AddrWidth: A read address (A row-major, NumParallelLanes k-elements per word).
- `sram_b_addr_o` out AddrWidth: B read address (B row-major, TileN n-elements per word).
- `sram_c_addr_o` out AddrWidth: C write address (TileN results per word).
- `sram_c_we_o` out 1: C write enable.
- `a_lane_sel_o` out $clog2(NumParallelLanes): selects the A byte within the returned A word.
- `mac_en_o` out 1: SRAM read data is valid this cycle; accumulate it.
- `acc_clr_o` out 1: qualifies `mac_en_o`; load the product instead of adding it (first k of a tile).
- `busy_o` out 1: high in any state other than IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: one-cycle pulse, coincident with `done_o`, for rejected sizes.

## Operation
- **States:** IDLE, RUN, WAIT, WRITE, DONE.
- **IDLE:**
  - On `start_i`=1, latch the sizes.
  - If M==0, K==0, N==0, K mod NumParallelLanes≠0 or N mod TileN≠0, go to DONE with the error flag set.
  - Otherwise clear the counters m, nb, k and go to RUN.
- **Loop order:** m from 0 to M-1 (outer), nb from 0 to N/TileN-1, k from 0 to K-1 (inner).
- **RUN:** each cycle issues one (m, nb, k) read.
  - a_addr = m*(K/NumParallelLanes) + k/NumParallelLanes.
  - b_addr = k*(N/TileN) + nb.
  - k increments each cycle.
  - When k==K-1, go to WAIT.
- **Address arithmetic:** use incremental base registers, no multipliers.
  - a_row_base += K/NumParallelLanes at each m step.
  - b_addr += N/TileN at each k step; it returns to nb at the start of each tile.
  - c_addr += 1 per tile.
  - All address arithmetic is mod 2^AddrWidth. Overflow is not flagged.
- **WAIT:** one cycle, no new read; it covers the last MAC.
- **WRITE:** one cycle.
  - `sram_c_we_o`=1 and `sram_c_addr_o` = m*(N/TileN) + nb; this equals the running tile count.
  - Then advance nb (and m when nb wraps).
  - If the last tile is done, go to DONE; otherwise clear k and go to RUN.
- **DONE:** one cycle.
  - `done_o`=1; `err_o`=1 if the error flag is set.
  - Go to IDLE.
- **`start_i` outside IDLE:** ignored; not queued.
- **Size inputs:** may change freely after the latch.

## Timing
- **Reset:** all outputs are 0, the state is IDLE, and all counters are 0. Reset is effective immediately and asynchronously, including mid-run; no partial `done_o` is produced.
- **SRAM read latency:** 1 cycle. A read issued in cycle t drives `mac_en_o`=1 in cycle t+1.
  - `a_lane_sel_o` = (k mod NumParallelLanes) of cycle t.
  - `acc_clr_o` = (k==0) of cycle t.
- **Address outputs:** `sram_a_addr_o` and `sram_b_addr_o` are registered. They hold the last issued value outside RUN, and are 0 after reset.
- **Write data:** the accumulator result is valid in the WRITE cycle. WRITE follows the last `mac_en_o` (the WAIT cycle) by exactly one cycle.
- **Cycles per tile:** K+2. Latency from the `start_i` edge to `done_o` is 1 + M*(N/TileN)*(K+2) cycles.
- **Rejected start:** `done_o` and `err_o` are asserted in the cycle after the `start_i` edge. `sram_c_we_o` never rises.

## Test plan
- **Minimal run:** M=1, K=4, N=16, `start_i` in cycle 0.
  - RUN cycles 1-4 with a_addr=0 throughout and b_addr=0,1,2,3.
  - `mac_en_o` in cycles 2-5, with `acc_clr_o` only in cycle 2 and `a_lane_sel_o`=0,1,2,3.
  - WRITE in cycle 6 with c_addr=0.
  - `done_o` in cycle 7 with `err_o`=0.
- **Full run with golden model:** M=4, K=16, N=64.
  - First tile: a_addr sequence 0,0,0,0,1,1,1,1,…,3; b_addr sequence 0,4,8,…,60.
  - 16 writes with c_addr 0..15 in order.
  - `done_o` 289 cycles after start.
  - Run it with the golden GEMM model and the memory models; C must match bit-exactly.
- **Rejected sizes:**
  - K=6 → `done_o`+`err_o` in cycle 1, zero writes.
  - N=0 → same response.
  - M=0 → same response.
- **Start while busy:** pulse `start_i` with different sizes during RUN. The sequence, write count and done time must be unchanged.
- **Reset mid-operation:** assert `rst_ni`=0 mid-RUN. All outputs drop to 0 asynchronously, the state is IDLE and `done_o` stays 0. A subsequent M=1, K=4, N=16 run reproduces the minimal-run response above.
- **Back-to-back runs:** assert `start_i` in the cycle after `done_o`. Addresses restart at 0, with no stale counters.
